// File: rtl/hello_world_pkg.sv
// Shared constants and types for the hello_world increment kernel.
package hello_world_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned INCR_DEFAULT   = 1;
  localparam int unsigned MAX_LATENCY    = 8;

  typedef logic [DATA_W_DEFAULT-1:0] data_t;

endpackage

// File: rtl/hello_world_pipe.sv
// LATENCY-stage valid+data delay line; data registers load only alongside their valid bit.
module hello_world_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        // Hold stale data on bubbles so the last stage keeps the previous result.
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_vld  = vld_q[LATENCY-1];
  assign out_data = data_q[LATENCY-1];
  assign busy     = |vld_q;

endmodule

// File: rtl/hello_world_core.sv
// Fully pipelined b = a + INCR kernel with ap_start/ap_done block control, II = 1.
module hello_world_core
  import hello_world_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned INCR    = INCR_DEFAULT,
  parameter int unsigned LATENCY = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [DATA_W-1:0] a,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  output logic [DATA_W-1:0] b,
  output logic              b_ap_vld
);

  // Out-of-range latencies are clamped into the supported 1..MAX_LATENCY window.
  localparam int unsigned Depth = (LATENCY < 1)           ? 1 :
                                  (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
  localparam logic [DATA_W-1:0] IncrW = DATA_W'(INCR);

  logic              accept;
  logic [DATA_W-1:0] sum;
  logic              out_vld;
  logic              busy;

  assign accept = ap_start & ~ap_rst;
  assign sum    = a + IncrW;

  hello_world_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (Depth)
  ) u_pipe (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_vld   (accept),
    .in_data  (sum),
    .out_vld  (out_vld),
    .out_data (b),
    .busy     (busy)
  );

  assign ap_ready = accept;
  assign ap_done  = out_vld;
  assign b_ap_vld = out_vld;
  assign ap_idle  = ~ap_start & ~busy;

endmodule

// File: tb/tb_hello_world_core.sv
// Bench for hello_world_core: three instances (LATENCY 1/INCR 1, LATENCY 3/INCR 1,
// LATENCY 1/INCR 3) share one stimulus stream and are each tracked by a result queue.
module tb_hello_world_core;

  localparam int NDut = 3;

  typedef struct {
    int          due;
    logic [31:0] val;
  } item_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic [31:0] a;

  logic        ready [NDut];
  logic        done  [NDut];
  logic        idle  [NDut];
  logic        vld   [NDut];
  logic [31:0] b     [NDut];

  int unsigned lat  [NDut] = '{1, 3, 1};
  int unsigned incr [NDut] = '{1, 1, 3};

  item_t       sb   [NDut][$];
  logic [31:0] hold [NDut];
  int          cyc;
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  for (genvar g = 0; g < NDut; g++) begin : gen_dut
    hello_world_core #(
      .DATA_W  (32),
      .INCR    ((g == 2) ? 3 : 1),
      .LATENCY ((g == 1) ? 3 : 1)
    ) u_dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ap_start (ap_start),
      .a        (a),
      .ap_ready (ready[g]),
      .ap_done  (done[g]),
      .ap_idle  (idle[g]),
      .b        (b[g]),
      .b_ap_vld (vld[g])
    );
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d: got %h expected %h", tag, d, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check every instance, then advance the model past the edge.
  task automatic cycle(input logic st, input logic [31:0] av, input logic rs);
    logic busy;
    logic exp_vld;
    ap_start = st;
    a        = av;
    ap_rst   = rs;
    #1;
    for (int d = 0; d < NDut; d++) begin
      busy    = (sb[d].size() != 0);
      exp_vld = busy && (sb[d][0].due == cyc);
      if (exp_vld) begin
        hold[d] = sb[d][0].val;
        void'(sb[d].pop_front());
      end
      chk("b_ap_vld", d, {31'd0, vld[d]},   {31'd0, exp_vld});
      chk("ap_done",  d, {31'd0, done[d]},  {31'd0, exp_vld});
      chk("b",        d, b[d],              hold[d]);
      chk("ap_ready", d, {31'd0, ready[d]}, {31'd0, st & ~rs});
      chk("ap_idle",  d, {31'd0, idle[d]},  {31'd0, ~st & ~busy});
    end
    @(posedge ap_clk);
    for (int d = 0; d < NDut; d++) begin
      if (rs) begin
        sb[d].delete();
        hold[d] = '0;
      end else if (st) begin
        sb[d].push_back('{due: cyc + int'(lat[d]), val: av + incr[d]});
      end
    end
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    a        = '0;
    cyc      = 0;
    for (int d = 0; d < NDut; d++) hold[d] = '0;
    repeat (2) @(posedge ap_clk);
    #1;

    // Reset state, then a quiet idle stretch.
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    idle_cycles(10);

    // Single operation.
    cycle(1'b1, 32'd5, 1'b0);
    idle_cycles(5);

    // Back-to-back stream of 40 operands.
    for (int i = 0; i < 40; i++) cycle(1'b1, 32'(i), 1'b0);
    idle_cycles(5);

    // Carry wrap.
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
    idle_cycles(5);

    // Bubbles: starts in relative cycles 0, 2, 3.
    cycle(1'b1, 32'd10, 1'b0);
    cycle(1'b0, 32'd0,  1'b0);
    cycle(1'b1, 32'd20, 1'b0);
    cycle(1'b1, 32'd30, 1'b0);
    idle_cycles(5);

    // Reset mid-flight, including a start presented during reset.
    cycle(1'b1, 32'd7,  1'b0);
    cycle(1'b0, 32'd0,  1'b1);
    cycle(1'b1, 32'd99, 1'b1);
    idle_cycles(6);

    for (int d = 0; d < NDut; d++) begin
      chk("drained", d, 32'(sb[d].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/hello_world_core.md
Name: hello_world_core

Overview:
- Fully pipelined scalar compute kernel with block-level start/done control, accepting one operand per cycle.
- Computes b = a + INCR, modulo 2^DATA_W.
- Sits behind a simple producer that drives ap_start/a each cycle and a consumer that samples b when b_ap_vld is high.
- No back-pressure: the consumer must accept every result.

Parameters:
- DATA_W, 32, width of operand a and result b.
- INCR, 1, constant added to every operand; only the low DATA_W bits are used.
- LATENCY, 1, cycles from operand acceptance to result; legal range 1..8.

Ports:
- ap_clk  in  1  single clock, all logic on rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_start  in  1  operand a is valid this cycle; request to start one operation.
- a  in  DATA_W  operand, sampled only when ap_start=1.
- ap_ready  out  1  operand accepted this cycle; combinational, equal to ap_start & ~ap_rst.
- ap_done  out  1  one-cycle pulse per completed operation.
- ap_idle  out  1  no operation in flight and ap_start=0.
- b  out  DATA_W  registered result.
- b_ap_vld  out  1  b holds a new result this cycle; identical to ap_done.

Behaviour:
- Clock/reset: one clock ap_clk; reset ap_rst is synchronous and active-high.
- Reset values, after the edge with ap_rst=1: b=0, b_ap_vld=0, ap_done=0, ap_idle=1. All in-flight operations are discarded.
- During reset cycles: ap_ready=0.
- Acceptance: on every rising edge with ap_start=1 and ap_rst=0, a is captured. Initiation interval is 1, so back-to-back starts are accepted every cycle.
- Latency: ap_start=1 in cycle n gives b = a(n)+INCR, with b_ap_vld=1 and ap_done=1, in cycle n+LATENCY. For LATENCY=1, this is the cycle immediately after acceptance.
- Ordering: results emerge strictly in acceptance order, one per accepted operand. Gaps in ap_start produce identical gaps in b_ap_vld.
- Hold: when b_ap_vld=0, b keeps its last value; it is never cleared except by reset.
- Arithmetic: unsigned DATA_W-bit add; carry discarded. Example: 0xFFFF_FFFF + 1 = 0x0000_0000.
- ap_idle = ~ap_start & (no valid bit set in the pipeline). It is combinational on ap_start, registered otherwise.
- Reset mid-operation: ap_rst=1 in any cycle kills all pending results. No b_ap_vld pulse appears for operands accepted before or during reset.
- ap_start asserted while ap_rst=1 is ignored; that operand is never processed.
- Structure: no internal state machine beyond a LATENCY-deep valid/data shift pipeline. The adder sits in stage 1; later stages are pure delay.
- No X propagation: a is ignored when ap_start=0, and pipeline data registers update only when their valid bit is loaded.

Decomposition:
- Package hello_world_pkg:
  - DATA_W default constant.
  - INCR default constant.
  - MAX_LATENCY = 8.
  - typedef data_t (DATA_W-bit logic).
- Sub-module hello_world_pipe: parameterised LATENCY-stage valid+data delay line.
  - Ports: ap_clk, ap_rst, in_vld, in_data, out_vld, out_data, busy.
  - busy = OR of stage valid bits.
  - The top instantiates it after the adder and derives ap_idle, ap_done and b_ap_vld from it.

Test Plan:
- Single op, LATENCY=1: a=5 with ap_start=1 for one cycle → next cycle b=6, b_ap_vld=ap_done=1 for exactly one cycle. ap_ready=1 in the start cycle. ap_idle=0 in the start cycle and the result cycle, then 1; b stays 6 afterwards.
- Stream: ap_start held 1 for 40 cycles with a=0,1,…,39 → b=1,2,…,40 on 40 consecutive cycles with b_ap_vld continuously high; no drops or duplicates.
- Wrap: a=0xFFFF_FFFF → b=0x0000_0000. Also check INCR=3 with a=0xFFFF_FFFE → b=0x0000_0001.
- Bubbles, LATENCY=3: starts in cycles 0, 2, 3 with a=10, 20, 30 → b_ap_vld in cycles 3, 5, 6 with b=11, 21, 31; b holds 11 in cycle 4.
- Reset mid-flight, LATENCY=3: start a=7 in cycle 0, ap_rst=1 in cycle 1 → no b_ap_vld pulse ever. After the reset edge: b=0, ap_idle=1, ap_ready=0 while ap_rst=1.
- Idle/ready: ap_start=0 for 10 cycles after reset → ap_idle=1, ap_ready=0, ap_done=0 throughout.
